// File: rtl/combat_scheduler.sv
// rtl/combat_scheduler.sv - projectile sequencing, cooldown and health bookkeeping for the battle stage
// One combat_shooter instance per combatant; the top owns synchronizers, edge detects and health.

module combat_shooter #(
  parameter logic [7:0] FLIGHT_FRAMES   = 8'd160,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic i_clear,
  input  logic i_rise,
  input  logic i_hit,
  input  logic i_tick,
  output logic o_fire,
  output logic o_idle,
  output logic o_hit_accept
);
  typedef enum logic [1:0] {IDLE, FIRE, FLIGHT, COOLDOWN} state_t;

  state_t     r_state;
  logic [7:0] r_cnt;
  logic       r_fire;

  assign o_fire       = r_fire;
  assign o_idle       = (r_state == IDLE);
  // A hit outranks a timeout tick in the same cycle, so acceptance ignores i_tick.
  assign o_hit_accept = (r_state == FLIGHT) & i_hit & ~i_clear;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 8'd0;
      r_fire  <= 1'b0;
    end else begin
      r_fire <= 1'b0;
      if (i_clear) begin
        r_state <= IDLE;
        r_cnt   <= 8'd0;
      end else begin
        case (r_state)
          IDLE: begin
            if (i_rise) begin
              r_state <= FIRE;
              r_fire  <= 1'b1;
            end
          end
          FIRE: begin
            r_state <= FLIGHT;
            r_cnt   <= 8'd0;
          end
          FLIGHT: begin
            if (i_hit) begin
              r_state <= COOLDOWN;
              r_cnt   <= 8'd0;
            end else if (i_tick) begin
              if (r_cnt == FLIGHT_FRAMES - 8'd1) begin
                r_state <= COOLDOWN;
                r_cnt   <= 8'd0;
              end else begin
                r_cnt <= r_cnt + 8'd1;
              end
            end
          end
          COOLDOWN: begin
            if (COOLDOWN_FRAMES == 8'd0) begin
              r_state <= IDLE;
            end else if (i_tick) begin
              if (r_cnt == COOLDOWN_FRAMES - 8'd1) r_state <= IDLE;
              else r_cnt <= r_cnt + 8'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

module combat_scheduler #(
  parameter logic [4:0] MAX_HEALTH      = 5'd16,
  parameter logic [4:0] DAMAGE          = 5'd1,
  parameter logic [7:0] FLIGHT_FRAMES   = 8'd160,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       battle_l,
  input  logic       player_shoot_req,
  input  logic       npc_shoot_req,
  input  logic       bullet_npc_contact,
  input  logic       bullet_player_contact,
  output logic       player_fire,
  output logic       npc_fire,
  output logic       player_ready,
  output logic       npc_ready,
  output logic [4:0] player_health,
  output logic [4:0] npc_health,
  output logic       Player_Dead,
  output logic       NPC_Dead
);
  logic       r_fs1, r_fs2, r_fs3;
  logic       r_preq_q, r_nreq_q, r_pcon_q, r_ncon_q, r_battle_q;
  logic [4:0] r_player_health, r_npc_health;

  logic w_tick, w_battle_rise, w_any_dead, w_clear;
  logic w_player_idle, w_npc_idle, w_npc_dmg, w_player_dmg;

  // frame_clk is VGA vsync from another domain: synchronize, then take the rising edge.
  assign w_tick        = r_fs2 & ~r_fs3;
  assign w_battle_rise = battle_l & ~r_battle_q;
  assign w_any_dead    = Player_Dead | NPC_Dead;
  assign w_clear       = ~battle_l | w_any_dead | w_battle_rise;

  assign Player_Dead   = (r_player_health == 5'd0);
  assign NPC_Dead      = (r_npc_health == 5'd0);
  assign player_health = r_player_health;
  assign npc_health    = r_npc_health;
  assign player_ready  = w_player_idle & battle_l & r_battle_q & ~w_any_dead;
  assign npc_ready     = w_npc_idle & battle_l & r_battle_q & ~w_any_dead;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      {r_fs1, r_fs2, r_fs3} <= 3'b000;
      r_preq_q        <= 1'b0;
      r_nreq_q        <= 1'b0;
      r_pcon_q        <= 1'b0;
      r_ncon_q        <= 1'b0;
      r_battle_q      <= 1'b0;
      r_player_health <= MAX_HEALTH;
      r_npc_health    <= MAX_HEALTH;
    end else begin
      {r_fs1, r_fs2, r_fs3} <= {frame_clk, r_fs1, r_fs2};
      r_preq_q   <= player_shoot_req;
      r_nreq_q   <= npc_shoot_req;
      r_pcon_q   <= bullet_npc_contact;
      r_ncon_q   <= bullet_player_contact;
      r_battle_q <= battle_l;
      if (w_battle_rise) begin
        r_player_health <= MAX_HEALTH;
        r_npc_health    <= MAX_HEALTH;
      end else begin
        if (w_npc_dmg)
          r_npc_health <= (r_npc_health > DAMAGE) ? r_npc_health - DAMAGE : 5'd0;
        if (w_player_dmg)
          r_player_health <= (r_player_health > DAMAGE) ? r_player_health - DAMAGE : 5'd0;
      end
    end
  end

  combat_shooter #(.FLIGHT_FRAMES(FLIGHT_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_player (
    .Clk(Clk), .Reset_n(Reset_n), .i_clear(w_clear),
    .i_rise(player_shoot_req & ~r_preq_q), .i_hit(bullet_npc_contact & ~r_pcon_q),
    .i_tick(w_tick), .o_fire(player_fire), .o_idle(w_player_idle), .o_hit_accept(w_npc_dmg)
  );

  combat_shooter #(.FLIGHT_FRAMES(FLIGHT_FRAMES), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)) u_npc (
    .Clk(Clk), .Reset_n(Reset_n), .i_clear(w_clear),
    .i_rise(npc_shoot_req & ~r_nreq_q), .i_hit(bullet_player_contact & ~r_ncon_q),
    .i_tick(w_tick), .o_fire(npc_fire), .o_idle(w_npc_idle), .o_hit_accept(w_player_dmg)
  );
endmodule
